tick_shifter: RTL
=================

// Module: tick_shifter
// PURPOSE
//  Consumer side of the slow-tick interface. The clock enable generator drives tick_en as a
//  toggle: each transition (0->1 or 1->0) is one step event. This block decodes those
//  transitions into single-cycle step strobes and advances a loadable shift/rotate register.
//  It runs under start/stop control with an optional step limit. Output drives the LED bank.
// PARAMETERS
//  WIDTH  8  shift register width, >=2
//  STEPS  0  shifts per run before auto-stop; 0 = free-run until stop
// PORTS
//  clk        in   1      sole clock
//  rst        in   1      asynchronous, active-high reset
//  tick_en    in   1      toggle-encoded step request, clk-domain registered, no sync needed
//  load       in   1      1-cycle strobe: q <= load_data, step count cleared
//  load_data  in   WIDTH  pattern for load
//  start      in   1      1-cycle strobe: IDLE -> RUN
//  stop       in   1      1-cycle strobe: RUN -> IDLE
//  dir        in   1      0 = left (q[0] toward q[WIDTH-1]), 1 = right
//  mode       in   1      0 = rotate, 1 = shift with ser_in into vacated bit
//  ser_in     in   1      fill bit for mode=1
//  q          out  WIDTH  register contents
//  step_pulse out  1      registered; high the cycle q shows a newly shifted value
//  busy       out  1      1 while in RUN
//  done       out  1      1-cycle pulse on auto-stop (STEPS>0 only)
// BEHAVIOUR
//  Reset (async assert, released on clk): q=0, tick_q=0, step_pulse=0, busy=0, done=0,
//   step_cnt=0, state=IDLE.
//  Edge decode: tick_q <= tick_en every cycle in all states; step = tick_en ^ tick_q.
//   tick_en changing before edge k gives a shift at edge k. Latency: 1 clk.
//  FSM: IDLE --start--> RUN; RUN --stop--> IDLE; RUN --STEPS-th shift--> DONE; DONE -> IDLE.
//   busy = (state==RUN). done = (state==DONE).
//  Shift occurs only when state==RUN && step && !stop && !load.
//   left rotate: q <= {q[W-2:0],q[W-1]}   right rotate: q <= {q[0],q[W-1:1]}
//   left shift:  q <= {q[W-2:0],ser_in}   right shift:  q <= {ser_in,q[W-1:1]}
//   step_pulse <= 1 on that edge, else 0.
//  Priority in one cycle: load > stop > step > start.
//   load in any state: q <= load_data, step_cnt <= 0, no shift, state unchanged.
//   stop with step: no shift, -> IDLE. start while RUN or DONE: ignored.
//  step_cnt: $clog2(STEPS+1) bits. Increments per shift, cleared on start/load/entry to DONE.
//   On the shift that makes step_cnt==STEPS: -> DONE. STEPS=0: counter is inert, no DONE.
//  Steps during IDLE/DONE: tick_q still tracks and the step is dropped, so re-entering RUN
//   gives no stale shift. tick period >> 2 clk, so no loss in practice.
//  Reset mid-run: everything returns to reset values immediately; q contents are lost.
// STRUCTURE
//  Package shift_pkg: typedef enum logic [1:0] {IDLE,RUN,DONE} tick_state_t;
//   localparams DIR_LEFT=1'b0, DIR_RIGHT=1'b1, MODE_ROT=1'b0, MODE_SHIFT=1'b1.
//  Sub-module tick_edge_detect (clk, rst, tick_en -> step): holds tick_q, reused by other
//   tick consumers. FSM, counter and shifter stay in tick_shifter.
// TESTING (WIDTH=8 unless noted)
//  1 rst=1 mid-run, async with no clk edge -> q=0, busy=0, done=0, step_pulse=0 at once.
//  2 load 8'h01, start, dir=0, mode=0, 3 tick_en toggles -> q=8'h02,8'h04,8'h08, one
//    step_pulse per toggle, each 1 clk after the toggle.
//  3 load 8'h80, dir=0 rotate, 1 toggle -> 8'h01; load 8'h01, dir=1, 1 toggle -> 8'h80.
//  4 load 8'h00, mode=1, dir=1, ser_in=1, 8 toggles -> 8'h80,8'hC0,...,8'hFF.
//  5 STEPS=4: start, 6 toggles -> exactly 4 shifts, done high 1 clk after 4th, busy=0,
//    toggles 5-6 ignored.
//  6 toggles while IDLE -> q unchanged. Toggle coincident with stop -> no shift, IDLE.
//    load coincident with toggle in RUN -> q=load_data, no shift.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and encodings for the tick-driven shift register.
package shift_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} tick_state_t;

  localparam logic DIR_LEFT   = 1'b0;
  localparam logic DIR_RIGHT  = 1'b1;
  localparam logic MODE_ROT   = 1'b0;
  localparam logic MODE_SHIFT = 1'b1;
endpackage

// File: rtl/tick_edge_detect.sv
// Decodes a toggle-encoded tick into a one-cycle step strobe.
// The step is combinational from the registered previous level, so it is valid the cycle tick_en changes.
module tick_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic tick_en,
  output logic step
);
  logic r_tick_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tick_q <= 1'b0;
    else     r_tick_q <= tick_en;
  end

  assign step = tick_en ^ r_tick_q;
endmodule

// File: rtl/tick_shifter.sv
// Tick-stepped shift/rotate register with start/stop control and an optional step limit.
// Priority within a cycle: load > stop > step > start.
module tick_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEPS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             step_pulse,
  output logic             busy,
  output logic             done
);
  // With STEPS=0 the counter is unused; keep one bit so the vector stays legal.
  localparam int CW = (STEPS > 0) ? $clog2(STEPS + 1) : 1;

  tick_state_t      r_state, w_next_state;
  logic [WIDTH-1:0] r_q, w_shifted;
  logic [CW-1:0]    r_cnt;
  logic             r_step_pulse;
  logic             w_step, w_shift, w_last;

  tick_edge_detect u_edge (
    .clk     (clk),
    .rst     (rst),
    .tick_en (tick_en),
    .step    (w_step)
  );

  assign w_shift = (r_state == RUN) && w_step && !stop && !load;
  assign w_last  = (STEPS > 0) && (r_cnt == CW'(STEPS - 1));

  always_comb begin
    w_shifted = r_q;
    case ({dir, mode})
      {DIR_LEFT,  MODE_ROT}:   w_shifted = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      {DIR_RIGHT, MODE_ROT}:   w_shifted = {r_q[0], r_q[WIDTH-1:1]};
      {DIR_LEFT,  MODE_SHIFT}: w_shifted = {r_q[WIDTH-2:0], ser_in};
      {DIR_RIGHT, MODE_SHIFT}: w_shifted = {ser_in, r_q[WIDTH-1:1]};
      default:                 w_shifted = r_q;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (!load && !stop && start) w_next_state = RUN;
      RUN: begin
        if (load)                   w_next_state = RUN;
        else if (stop)              w_next_state = IDLE;
        else if (w_shift && w_last) w_next_state = DONE;
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q          <= '0;
      r_step_pulse <= 1'b0;
    end else begin
      r_step_pulse <= w_shift;
      if (load)         r_q <= load_data;
      else if (w_shift) r_q <= w_shifted;
    end
  end

  // Cleared on load, on an accepted start and on the shift that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= '0;
    end else if ((r_state == IDLE) && start && !stop) begin
      r_cnt <= '0;
    end else if (w_shift && (STEPS > 0)) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

  assign q          = r_q;
  assign step_pulse = r_step_pulse;
  assign busy       = (r_state == RUN);
  assign done       = (r_state == DONE);
endmodule
